// File: rtl/sb_arbiter_pkg.sv
// Shared types and constants for the system-bus data-memory arbiter.
package sb_arbiter_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int SEL_W       = 4;
  localparam int SB_MASTER_W = 1;

  localparam logic READ_EN  = 1'b0;
  localparam logic WRITE_EN = 1'b1;

  localparam logic [SEL_W-1:0]  MASK_BYTE = 4'b0001;
  localparam logic [SEL_W-1:0]  MASK_HALF = 4'b0011;
  localparam logic [SEL_W-1:0]  MASK_WORD = 4'b1111;
  localparam logic [DATA_W-1:0] ZERO32    = '0;

  typedef enum logic {
    SB_IDLE    = 1'b0,
    SB_RD_WAIT = 1'b1
  } sb_state_t;

  typedef logic [SB_MASTER_W-1:0] sb_master_t;
  localparam sb_master_t SB_M0 = 1'b0;
  localparam sb_master_t SB_M1 = 1'b1;

  typedef struct packed {
    logic              we;
    logic              un_sign;
    logic [SEL_W-1:0]  byte_mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sb_req_t;

  // Anything that is not a byte or half mask is treated as a full word.
  function automatic logic [SEL_W-1:0] norm_mask(input logic [SEL_W-1:0] m);
    return (m == MASK_BYTE || m == MASK_HALF) ? m : MASK_WORD;
  endfunction

endpackage

// File: rtl/sb_arbiter_if.sv
// Per-master request/response bundle of the shared data-memory port.
interface sb_arbiter_if;
  import sb_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic              un_sign;
  logic [SEL_W-1:0]  byte_mask;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt_o;
  logic              rvalid_o;
  logic [DATA_W-1:0] rdata_o;

  modport master (output req, we, un_sign, byte_mask, addr, wdata,
                  input  gnt_o, rvalid_o, rdata_o);
  modport slave  (input  req, we, un_sign, byte_mask, addr, wdata,
                  output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/sb_lane_align.sv
// Byte-lane alignment: write mask/data shift and read shift with sign/zero extension.
module sb_lane_align
  import sb_arbiter_pkg::*;
(
  input  logic [SEL_W-1:0]  byte_mask,
  input  logic [1:0]        off,
  input  logic              un_sign,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [SEL_W-1:0]  wmask_sh,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [SEL_W-1:0]  mask_n;
  logic [4:0]        bit_off;
  logic [DATA_W-1:0] r_sh;

  // Lanes shifted past lane 3 simply fall off the top.
  assign mask_n   = norm_mask(byte_mask);
  assign bit_off  = {off, 3'b000};
  assign wmask_sh = mask_n << off;
  assign wdata_sh = wdata << bit_off;
  assign r_sh     = rdata >> bit_off;

  // Extend byte/half reads from their top bit unless zero-extension is requested.
  always_comb begin
    rdata_ext = r_sh;
    case (mask_n)
      MASK_BYTE: rdata_ext = {{(DATA_W-8){~un_sign & r_sh[7]}}, r_sh[7:0]};
      MASK_HALF: rdata_ext = {{(DATA_W-16){~un_sign & r_sh[15]}}, r_sh[15:0]};
      default:   rdata_ext = r_sh;
    endcase
  end

endmodule

// File: rtl/sb_arbiter.sv
// Two-master arbiter/sequencer for the shared 1-cycle synchronous-read data memory.
// m0 has fixed priority; optional m1 starvation guard under SB_ARB_STARVE_GUARD_EN.
module sb_arbiter
  import sb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  sb_arbiter_if.slave       m0,
  sb_arbiter_if.slave       m1,
  output logic              s_en_o,
  output logic              s_rw_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [SEL_W-1:0]  s_wmask_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata
);

  sb_state_t         state, state_nxt;
  sb_master_t        owner, win;
  sb_req_t           req0, req1, win_req;
  logic              go, gnt0, gnt1, m1_first;
  logic [SEL_W-1:0]  lat_mask;
  logic [1:0]        lat_off;
  logic              lat_uns;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic [SEL_W-1:0]  wr_wmask, rd_wmask;
  logic [DATA_W-1:0] wr_wdata, rd_wdata, wr_rext, rd_rext;
  logic              unused_lane;

  assign req0 = '{we: m0.we, un_sign: m0.un_sign, byte_mask: m0.byte_mask,
                  addr: m0.addr, wdata: m0.wdata};
  assign req1 = '{we: m1.we, un_sign: m1.un_sign, byte_mask: m1.byte_mask,
                  addr: m1.addr, wdata: m1.wdata};

  sb_lane_align u_wr_align (
    .byte_mask (win_req.byte_mask),
    .off       (win_req.addr[1:0]),
    .un_sign   (1'b0),
    .wdata     (win_req.wdata),
    .rdata     (ZERO32),
    .wmask_sh  (wr_wmask),
    .wdata_sh  (wr_wdata),
    .rdata_ext (wr_rext)
  );

  sb_lane_align u_rd_align (
    .byte_mask (lat_mask),
    .off       (lat_off),
    .un_sign   (lat_uns),
    .wdata     (ZERO32),
    .rdata     (s_rdata),
    .wmask_sh  (rd_wmask),
    .wdata_sh  (rd_wdata),
    .rdata_ext (rd_rext)
  );

  // Each instance only uses one direction of the aligner.
  assign unused_lane = ^{wr_rext, rd_wmask, rd_wdata};

`ifdef SB_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt;

  // Count cycles m1 is kept waiting; saturate at the limit, clear on m1 grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                             starve_cnt <= '0;
    else if (gnt1)                                        starve_cnt <= '0;
    else if (m1.req && starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  end

  assign m1_first = m1.req && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  logic [CNT_W-1:0] unused_starve;
  assign unused_starve = CNT_W'(STARVE_LIMIT);
  assign m1_first      = 1'b0;
`endif

  // Winner selection, next state and memory strobe; everything idles while in reset.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    win       = SB_M0;
    win_req   = req0;
    s_en_o    = 1'b0;
    s_rw_o    = READ_EN;
    s_addr_o  = ZERO32;
    s_wmask_o = '0;
    s_wdata_o = ZERO32;
    if (rst) begin
      case (state)
        SB_IDLE: begin
          if (m1_first || (m1.req && !m0.req)) begin
            go = 1'b1; gnt1 = 1'b1; win = SB_M1; win_req = req1;
          end else if (m0.req) begin
            go = 1'b1; gnt0 = 1'b1;
          end
          if (go) begin
            s_en_o   = 1'b1;
            s_addr_o = {win_req.addr[ADDR_W-1:2], 2'b00};
            if (win_req.we) begin
              s_rw_o    = WRITE_EN;
              s_wmask_o = wr_wmask;
              s_wdata_o = wr_wdata;
            end else begin
              state_nxt = SB_RD_WAIT;
            end
          end
        end
        SB_RD_WAIT: state_nxt = SB_IDLE;
        default:    state_nxt = SB_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SB_IDLE;
    else      state <= state_nxt;
  end

  // Remember who issued the read and how to align its data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= SB_M0;
      lat_mask <= '0;
      lat_off  <= '0;
      lat_uns  <= 1'b0;
    end else if (go && !win_req.we) begin
      owner    <= win;
      lat_mask <= win_req.byte_mask;
      lat_off  <= win_req.addr[1:0];
      lat_uns  <= win_req.un_sign;
    end
  end

  // Capture memory data in the wait cycle; rvalid pulses for the owner only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= ZERO32;
      rdata1  <= ZERO32;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state == SB_RD_WAIT) begin
        if (owner == SB_M1) begin
          rdata1  <= rd_rext;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= rd_rext;
          rvalid0 <= 1'b1;
        end
      end
    end
  end

  assign m0.gnt_o    = gnt0;
  assign m1.gnt_o    = gnt1;
  assign m0.rvalid_o = rvalid0;
  assign m1.rvalid_o = rvalid1;
  assign m0.rdata_o  = rdata0;
  assign m1.rdata_o  = rdata1;

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed bench for sb_arbiter with a 1-cycle synchronous-read memory model.
module tb_sb_arbiter;
  import sb_arbiter_pkg::*;

  logic        clk, rst;
  logic        s_en, s_rw;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  sb_arbiter_if m0_if ();
  sb_arbiter_if m1_if ();

  sb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s_en_o    (s_en),
    .s_rw_o    (s_rw),
    .s_addr_o  (s_addr),
    .s_wmask_o (s_wmask),
    .s_wdata_o (s_wdata),
    .s_rdata   (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_en && s_rw == WRITE_EN)
      for (int b = 0; b < 4; b++)
        if (s_wmask[b]) mem[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    if (s_en && s_rw == READ_EN) s_rdata <= mem[s_addr[9:2]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int mst, input logic we, input logic uns,
                         input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] wd);
    if (mst == 0) begin
      m0_if.we = we; m0_if.un_sign = uns; m0_if.byte_mask = mask;
      m0_if.addr = addr; m0_if.wdata = wd; m0_if.req = 1'b1;
    end else begin
      m1_if.we = we; m1_if.un_sign = uns; m1_if.byte_mask = mask;
      m1_if.addr = addr; m1_if.wdata = wd; m1_if.req = 1'b1;
    end
  endtask

  task automatic drop(input int mst);
    if (mst == 0) m0_if.req = 1'b0;
    else          m1_if.req = 1'b0;
  endtask

  function automatic logic gnt_of(input int mst);
    return (mst == 0) ? m0_if.gnt_o : m1_if.gnt_o;
  endfunction

  function automatic logic rv_of(input int mst);
    return (mst == 0) ? m0_if.rvalid_o : m1_if.rvalid_o;
  endfunction

  function automatic logic [31:0] rd_of(input int mst);
    return (mst == 0) ? m0_if.rdata_o : m1_if.rdata_o;
  endfunction

  // Issue at current cycle T, expect rvalid only at T+2.
  task automatic do_read(input int mst, input logic uns, input logic [3:0] mask,
                         input logic [31:0] addr, input logic [31:0] exp, input string tag);
    set_req(mst, 1'b0, uns, mask, addr, 32'h0);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt_of(mst)), 32'd1);
    chk({tag, "_addr"}, s_addr, {addr[31:2], 2'b00});
    step(); drop(mst);
    @(negedge clk);
    chk({tag, "_rv_t1"}, 32'(rv_of(mst)), 32'd0);
    step();
    @(negedge clk);
    chk({tag, "_rv_t2"}, 32'(rv_of(mst)), 32'd1);
    chk({tag, "_rdata"}, rd_of(mst), exp);
    chk({tag, "_rv_other"}, 32'(rv_of(1 - mst)), 32'd0);
    step();
  endtask

  task automatic do_write(input int mst, input logic [3:0] mask, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wd, input logic [31:0] exp_addr, input string tag);
    set_req(mst, 1'b1, 1'b0, mask, addr, wd);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(gnt_of(mst)), 32'd1);
    chk({tag, "_rw"}, 32'(s_rw), 32'd1);
    chk({tag, "_addr"}, s_addr, exp_addr);
    chk({tag, "_wmask"}, 32'(s_wmask), 32'(exp_mask));
    chk({tag, "_wdata"}, s_wdata, exp_wd);
    step(); drop(mst);
  endtask

  initial begin
    int first1, n0, nrv1;
    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    mem[8'h40] <= 32'h80FF1234;   // 0x100
    mem[8'h08] <= 32'hCAFEF00D;   // 0x20
    rst = 1'b0;
    m0_if.req = 0; m0_if.we = 0; m0_if.un_sign = 0; m0_if.byte_mask = 0; m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.we = 0; m1_if.un_sign = 0; m1_if.byte_mask = 0; m1_if.addr = 0; m1_if.wdata = 0;

    // Reset state with a pending request
    step();
    set_req(0, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    @(negedge clk);
    chk("rst_gnt0", 32'(m0_if.gnt_o), 32'd0);
    chk("rst_s_en", 32'(s_en), 32'd0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_rw", 32'(s_rw), 32'd0);
    chk("rst_s_wmask", 32'(s_wmask), 32'd0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_rv0", 32'(m0_if.rvalid_o), 32'd0);
    chk("rst_rd0", m0_if.rdata_o, 32'h0);
    chk("rst_rd1", m1_if.rdata_o, 32'h0);

    // First grant right after release; req held through RD_WAIT gets no grant
    step(); rst = 1'b1;
    @(negedge clk);
    chk("first_gnt0", 32'(m0_if.gnt_o), 32'd1);
    chk("first_addr", s_addr, 32'h100);
    step();
    @(negedge clk);
    chk("wait_gnt0", 32'(m0_if.gnt_o), 32'd0);
    chk("wait_s_en", 32'(s_en), 32'd0);
    chk("wait_rv0", 32'(m0_if.rvalid_o), 32'd0);
    step(); drop(0);
    @(negedge clk);
    chk("first_rv0", 32'(m0_if.rvalid_o), 32'd1);
    chk("first_rd0", m0_if.rdata_o, 32'h80FF1234);
    step();
    @(negedge clk);
    chk("first_rv0_end", 32'(m0_if.rvalid_o), 32'd0);
    step();

    // Byte/half reads with extension
    do_read(1, 1'b0, 4'b0001, 32'h103, 32'hFFFFFF80, "t2_sext");
    do_read(1, 1'b1, 4'b0001, 32'h103, 32'h00000080, "t2_zext");
    do_read(0, 1'b0, 4'b0011, 32'h102, 32'hFFFF80FF, "t2_half");

    // Simultaneous m0 write and m1 read
    set_req(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h11223344);
    set_req(1, 1'b0, 1'b0, 4'hF, 32'h20, 32'h0);
    @(negedge clk);
    chk("t3_gnt0", 32'(m0_if.gnt_o), 32'd1);
    chk("t3_gnt1", 32'(m1_if.gnt_o), 32'd0);
    chk("t3_rw", 32'(s_rw), 32'd1);
    chk("t3_addr", s_addr, 32'h10);
    step(); drop(0);
    @(negedge clk);
    chk("t3_gnt1_c1", 32'(m1_if.gnt_o), 32'd1);
    chk("t3_rw_c1", 32'(s_rw), 32'd0);
    chk("t3_addr_c1", s_addr, 32'h20);
    step(); drop(1);
    step();
    @(negedge clk);
    chk("t3_rv1", 32'(m1_if.rvalid_o), 32'd1);
    chk("t3_rd1", m1_if.rdata_o, 32'hCAFEF00D);
    step();
    do_read(0, 1'b0, 4'hF, 32'h10, 32'h11223344, "t3_wb");

    // Lane-shifted writes
    do_write(0, 4'b0011, 32'h202, 32'h0000ABCD, 4'b1100, 32'hABCD0000, 32'h200, "t4_half");
    do_read(0, 1'b0, 4'hF, 32'h200, 32'hABCD0000, "t4_rb");
    do_write(1, 4'b0001, 32'h201, 32'h0000005A, 4'b0010, 32'h00005A00, 32'h200, "t4_byte");
    do_read(1, 1'b0, 4'b0001, 32'h201, 32'h0000005A, "t4_rbb");
    do_read(0, 1'b0, 4'hF, 32'h200, 32'hABCD5A00, "t4_rbw");
    do_write(0, 4'b0011, 32'h303, 32'h0000BEEF, 4'b1000, 32'hEF000000, 32'h300, "t4_mis");
    do_write(0, 4'b0101, 32'h304, 32'h12345678, 4'b1111, 32'h12345678, 32'h304, "t4_odd");

    // Asynchronous reset in the middle of a grant cycle
    set_req(0, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    #2;
    chk("async_pre_gnt", 32'(m0_if.gnt_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_gnt0", 32'(m0_if.gnt_o), 32'd0);
    chk("async_s_en", 32'(s_en), 32'd0);
    chk("async_addr", s_addr, 32'h0);
    chk("async_rd0", m0_if.rdata_o, 32'h0);
    step(); step(); rst = 1'b1;
    @(negedge clk);
    chk("async_first_gnt", 32'(m0_if.gnt_o), 32'd1);
    step(); drop(0);
    step();
    @(negedge clk);
    chk("async_rv0", 32'(m0_if.rvalid_o), 32'd1);
    chk("async_rd0b", m0_if.rdata_o, 32'h80FF1234);
    step();

    // Reset during RD_WAIT discards the response
    set_req(1, 1'b0, 1'b0, 4'hF, 32'h20, 32'h0);
    @(negedge clk);
    chk("t6_gnt1", 32'(m1_if.gnt_o), 32'd1);
    step(); drop(1);
    #1 rst = 1'b0;
    step(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6_rv1_%0d", i), 32'(m1_if.rvalid_o), 32'd0);
      chk($sformatf("t6_rv0_%0d", i), 32'(m0_if.rvalid_o), 32'd0);
      step();
    end
    do_read(1, 1'b1, 4'b0001, 32'h101, 32'h00000012, "t6_after");

    // Continuous m0 reads with m1 waiting
    rst = 1'b0; step(); rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'hF, 32'h20, 32'h0);
    first1 = -1; n0 = 0; nrv1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m1_if.gnt_o && first1 < 0) first1 = i;
      if (m0_if.gnt_o) n0++;
      if (m1_if.rvalid_o) nrv1++;
      step();
      if (first1 == i) drop(1);
    end
    drop(0); drop(1);
    step(); step(); step();
`ifdef SB_ARB_STARVE_GUARD_EN
    chk("t5_first_m1", 32'(first1), 32'd4);
    chk("t5_m0_grants", 32'(n0), 32'd5);
    chk("t5_m1_rvalids", 32'(nrv1), 32'd1);
`else
    chk("t5_first_m1", 32'(first1), 32'hFFFFFFFF);
    chk("t5_m0_grants", 32'(n0), 32'd6);
    chk("t5_m1_rvalids", 32'(nrv1), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
